// File: rtl/instr_mem_responder_if.sv
// Instruction-fetch bus between a fetch initiator (master) and an instruction memory (slave).
interface instr_mem_responder_if #(
    parameter int WORD_WIDTH = 32
);
    logic                  req;
    logic [WORD_WIDTH-1:0] addr;
    logic                  gnt;
    logic                  rvalid;
    logic [WORD_WIDTH-1:0] rdata;
    logic                  err;

    modport master (
        output req,
        output addr,
        input  gnt,
        input  rvalid,
        input  rdata,
        input  err
    );

    modport slave (
        input  req,
        input  addr,
        output gnt,
        output rvalid,
        output rdata,
        output err
    );
endinterface

// File: rtl/instr_mem_responder.sv
// Instruction memory on the fetch bus: in-order reads with fixed latency, bounded outstanding
// requests, grant back-pressure and a side preload port.
module instr_mem_responder #(
    parameter int                    WORD_WIDTH      = 32,
    parameter int                    DEPTH_WORDS     = 1024,
    parameter int                    LATENCY         = 1,
    parameter int                    MAX_OUTSTANDING = 2,
    parameter logic [WORD_WIDTH-1:0] BASE_ADDR       = '0,
    localparam int                   IDX_W           = $clog2(DEPTH_WORDS),
    localparam int                   CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    instr_mem_responder_if.slave    bus,
    input  logic                    stall_i,
    input  logic                    load_we_i,
    input  logic [IDX_W-1:0]        load_addr_i,
    input  logic [WORD_WIDTH-1:0]   load_wdata_i,
    output logic [CNT_W-1:0]        outstanding_o
);

    localparam logic [WORD_WIDTH-1:0] DEPTH_LIMIT = WORD_WIDTH'(DEPTH_WORDS);
    localparam logic [CNT_W-1:0]      CNT_MAX     = CNT_W'(MAX_OUTSTANDING);

    logic [1:0]            rst_sync;
    logic                  rst_int_n;
    logic [WORD_WIDTH-1:0] mem [DEPTH_WORDS];
    logic [WORD_WIDTH-1:0] offset;
    logic [WORD_WIDTH-1:0] word_idx;
    logic [IDX_W-1:0]      rd_idx;
    logic                  addr_err;
    logic [WORD_WIDTH-1:0] rd_word;
    logic                  grant;

    logic [LATENCY-1:0]                 pipe_valid;
    logic [LATENCY-1:0]                 pipe_err;
    logic [LATENCY-1:0][WORD_WIDTH-1:0] pipe_data;

    // Reset asserts immediately but releases on a clock edge, so no grant races the release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync[1];

    always_comb begin
        offset   = bus.addr - BASE_ADDR;
        word_idx = offset >> 2;
        rd_idx   = word_idx[IDX_W-1:0];
        addr_err = (bus.addr[1:0] != 2'b00) || (word_idx >= DEPTH_LIMIT);
        rd_word  = addr_err ? '0 : mem[rd_idx];
    end

    // The count is registered, so a slot freed by this cycle's rvalid only frees up next cycle.
    assign grant   = bus.req & ~stall_i & rst_int_n & (outstanding_o < CNT_MAX);
    assign bus.gnt = grant;

    // The array is never reset; a same-cycle grant reads the old word before this write lands.
    always_ff @(posedge clk) begin
        if (load_we_i) begin
            mem[load_addr_i] <= load_wdata_i;
        end
    end

    // Empty slots carry zero data and err so the outputs idle at zero between responses.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            pipe_valid <= '0;
            pipe_err   <= '0;
            pipe_data  <= '0;
        end else begin
            pipe_valid[0] <= grant;
            pipe_err[0]   <= grant & addr_err;
            pipe_data[0]  <= grant ? rd_word : '0;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_err[i]   <= pipe_err[i-1];
                pipe_data[i]  <= pipe_data[i-1];
            end
        end
    end

    assign bus.rvalid = pipe_valid[LATENCY-1];
    assign bus.err    = pipe_err[LATENCY-1];
    assign bus.rdata  = pipe_data[LATENCY-1];

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            outstanding_o <= '0;
        end else begin
            case ({grant, bus.rvalid})
                2'b10:   outstanding_o <= outstanding_o + CNT_W'(1);
                2'b01:   outstanding_o <= outstanding_o - CNT_W'(1);
                default: outstanding_o <= outstanding_o;
            endcase
        end
    end

    a_outstanding_bound : assert property (@(posedge clk) disable iff (!rst_int_n)
        outstanding_o <= CNT_MAX);

endmodule

// File: tb/tb_instr_mem_responder.sv
// Bench for instr_mem_responder: two instances (latency 1 and 3) checked against a
// cycle-scheduled reference model, plus directed tables and multi-cycle sequences.
module tb_instr_mem_responder;

    localparam int W     = 32;
    localparam int DEPTH = 64;
    localparam int IDX_W = 6;
    localparam int MAXO  = 2;
    localparam int LAT0  = 1;
    localparam int LAT1  = 3;

    typedef struct {
        int          inst;
        logic        req;
        logic [31:0] addr;
        logic        exp_gnt;
        logic        exp_rv;
        logic [31:0] exp_rd;
        logic        exp_err;
        logic [1:0]  exp_out;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;

    logic [1:0]            req_d;
    logic [1:0][31:0]      addr_d;
    logic [1:0]            stall_d;
    logic [1:0]            we_d;
    logic [1:0][IDX_W-1:0] la_d;
    logic [1:0][31:0]      wd_d;

    logic [1:0]       gnt_w;
    logic [1:0]       rv_w;
    logic [1:0][31:0] rd_w;
    logic [1:0]       err_w;
    logic [1:0][1:0]  out_w;

    // Reference model: memory image plus responses scheduled by the cycle they are due.
    logic [31:0] mem_m   [2][DEPTH];
    logic        sched_v [2][16];
    logic        sched_e [2][16];
    logic [31:0] sched_d [2][16];
    int          pending [2];
    int          cyc;
    int          rel_edges;
    int          checks;
    int          failures;

    logic [31:0] prog [4];
    vec_t        tbl  [21];

    instr_mem_responder_if #(.WORD_WIDTH(W)) bus0 ();
    instr_mem_responder_if #(.WORD_WIDTH(W)) bus1 ();

    assign bus0.req  = req_d[0];
    assign bus0.addr = addr_d[0];
    assign gnt_w[0]  = bus0.gnt;
    assign rv_w[0]   = bus0.rvalid;
    assign rd_w[0]   = bus0.rdata;
    assign err_w[0]  = bus0.err;
    assign bus1.req  = req_d[1];
    assign bus1.addr = addr_d[1];
    assign gnt_w[1]  = bus1.gnt;
    assign rv_w[1]   = bus1.rvalid;
    assign rd_w[1]   = bus1.rdata;
    assign err_w[1]  = bus1.err;

    instr_mem_responder #(
        .WORD_WIDTH(W), .DEPTH_WORDS(DEPTH), .LATENCY(LAT0),
        .MAX_OUTSTANDING(MAXO), .BASE_ADDR(32'h0000_0000)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0), .stall_i(stall_d[0]),
        .load_we_i(we_d[0]), .load_addr_i(la_d[0]), .load_wdata_i(wd_d[0]),
        .outstanding_o(out_w[0])
    );

    instr_mem_responder #(
        .WORD_WIDTH(W), .DEPTH_WORDS(DEPTH), .LATENCY(LAT1),
        .MAX_OUTSTANDING(MAXO), .BASE_ADDR(32'h0000_0000)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1), .stall_i(stall_d[1]),
        .load_we_i(we_d[1]), .load_addr_i(la_d[1]), .load_wdata_i(wd_d[1]),
        .outstanding_o(out_w[1])
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog cycle=%0d actual=timeout required=finish", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int lat_of(input int i);
        return (i == 0) ? LAT0 : LAT1;
    endfunction

    function automatic vec_t mk(input int inst, input logic req, input logic [31:0] addr,
                                input logic g, input logic rv, input logic [31:0] rd,
                                input logic er, input logic [1:0] o);
        vec_t v;
        v.inst = inst; v.req = req; v.addr = addr; v.exp_gnt = g;
        v.exp_rv = rv; v.exp_rd = rd; v.exp_err = er; v.exp_out = o;
        return v;
    endfunction

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    task automatic idle_all();
        req_d   = '0;
        stall_d = '0;
        we_d    = '0;
        for (int i = 0; i < 2; i++) begin
            addr_d[i] = '0;
            la_d[i]   = '0;
            wd_d[i]   = '0;
        end
    endtask

    task automatic apply_stimulus(input int i, input logic req, input logic [31:0] addr,
                                  input logic stall);
        req_d[i]   = req;
        addr_d[i]  = addr;
        stall_d[i] = stall;
    endtask

    task automatic set_load(input int i, input logic we, input logic [IDX_W-1:0] la,
                            input logic [31:0] wd);
        we_d[i] = we;
        la_d[i] = la;
        wd_d[i] = wd;
    endtask

    // Compares one instance against the model for the current cycle, then advances the model.
    task automatic check_output(input int i);
        int          slot;
        int          due;
        logic        exp_gnt;
        logic        exp_rv;
        logic        exp_err;
        logic        e;
        logic [31:0] exp_rd;
        logic [31:0] idx;
        if (!rst_n) begin
            for (int s = 0; s < 16; s++) sched_v[i][s] = 1'b0;
            pending[i] = 0;
            check_val($sformatf("u%0d.rst.gnt", i), gnt_w[i], 0);
            check_val($sformatf("u%0d.rst.rvalid", i), rv_w[i], 0);
            check_val($sformatf("u%0d.rst.rdata", i), rd_w[i], 0);
            check_val($sformatf("u%0d.rst.err", i), err_w[i], 0);
            check_val($sformatf("u%0d.rst.outstanding", i), out_w[i], 0);
        end else begin
            slot    = cyc % 16;
            exp_rv  = sched_v[i][slot];
            exp_rd  = exp_rv ? sched_d[i][slot] : 32'h0;
            exp_err = exp_rv ? sched_e[i][slot] : 1'b0;
            exp_gnt = req_d[i] && !stall_d[i] && (rel_edges >= 2) && (pending[i] < MAXO);
            check_val($sformatf("u%0d.model.gnt", i), gnt_w[i], exp_gnt);
            check_val($sformatf("u%0d.model.rvalid", i), rv_w[i], exp_rv);
            check_val($sformatf("u%0d.model.rdata", i), rd_w[i], exp_rd);
            check_val($sformatf("u%0d.model.err", i), err_w[i], exp_err);
            check_val($sformatf("u%0d.model.outstanding", i), out_w[i], pending[i]);
            if (exp_rv) begin
                sched_v[i][slot] = 1'b0;
                pending[i]--;
            end
            if (exp_gnt) begin
                idx = addr_d[i] >> 2;
                e   = (addr_d[i][1:0] != 2'b00) || (idx >= DEPTH);
                due = (cyc + lat_of(i)) % 16;
                sched_v[i][due] = 1'b1;
                sched_e[i][due] = e;
                sched_d[i][due] = e ? 32'h0 : mem_m[i][idx[IDX_W-1:0]];
                pending[i]++;
            end
        end
        if (we_d[i]) mem_m[i][la_d[i]] = wd_d[i];
    endtask

    task automatic to_negedge();
        @(negedge clk);
        check_output(0);
        check_output(1);
    endtask

    task automatic advance();
        @(posedge clk);
        cyc++;
        if (rst_n) rel_edges++;
        else       rel_edges = 0;
        #1;
    endtask

    task automatic step();
        to_negedge();
        advance();
    endtask

    task automatic run_row(input int k, input vec_t r);
        idle_all();
        apply_stimulus(r.inst, r.req, r.addr, 1'b0);
        to_negedge();
        check_val($sformatf("tbl%0d.gnt", k), gnt_w[r.inst], r.exp_gnt);
        check_val($sformatf("tbl%0d.rvalid", k), rv_w[r.inst], r.exp_rv);
        check_val($sformatf("tbl%0d.rdata", k), rd_w[r.inst], r.exp_rd);
        check_val($sformatf("tbl%0d.err", k), err_w[r.inst], r.exp_err);
        check_val($sformatf("tbl%0d.outstanding", k), out_w[r.inst], r.exp_out);
        advance();
    endtask

    task automatic drain(input string tag);
        idle_all();
        for (int k = 0; k < 20 && (pending[0] != 0 || pending[1] != 0); k++) step();
        step();
        check_val({tag, ".drain0"}, out_w[0], 0);
        check_val({tag, ".drain1"}, out_w[1], 0);
    endtask

    initial begin
        logic [31:0] a;
        int          r;
        int          t;
        checks    = 0;
        failures  = 0;
        cyc       = 0;
        rel_edges = 0;
        pending[0] = 0;
        pending[1] = 0;
        for (int i = 0; i < 2; i++)
            for (int s = 0; s < 16; s++) sched_v[i][s] = 1'b0;
        rst_n = 1'b0;
        idle_all();

        prog[0] = 32'h0000_0013;
        prog[1] = 32'h0010_0093;
        prog[2] = 32'h0020_8113;
        prog[3] = 32'h0031_81b3;

        // Latency 1: back-to-back fetches of words 0..3
        tbl[0]  = mk(0, 1'b1, 32'd0,  1'b1, 1'b0, 32'h0,    1'b0, 2'd0);
        tbl[1]  = mk(0, 1'b1, 32'd4,  1'b1, 1'b1, prog[0],  1'b0, 2'd1);
        tbl[2]  = mk(0, 1'b1, 32'd8,  1'b1, 1'b1, prog[1],  1'b0, 2'd1);
        tbl[3]  = mk(0, 1'b1, 32'd12, 1'b1, 1'b1, prog[2],  1'b0, 2'd1);
        tbl[4]  = mk(0, 1'b0, 32'd0,  1'b0, 1'b1, prog[3],  1'b0, 2'd1);
        tbl[5]  = mk(0, 1'b0, 32'd0,  1'b0, 1'b0, 32'h0,    1'b0, 2'd0);
        // Latency 3 with two outstanding: grant stalls until a slot frees
        tbl[6]  = mk(1, 1'b1, 32'd0,  1'b1, 1'b0, 32'h0,    1'b0, 2'd0);
        tbl[7]  = mk(1, 1'b1, 32'd4,  1'b1, 1'b0, 32'h0,    1'b0, 2'd1);
        tbl[8]  = mk(1, 1'b1, 32'd8,  1'b0, 1'b0, 32'h0,    1'b0, 2'd2);
        tbl[9]  = mk(1, 1'b1, 32'd8,  1'b0, 1'b1, prog[0],  1'b0, 2'd2);
        tbl[10] = mk(1, 1'b1, 32'd8,  1'b1, 1'b1, prog[1],  1'b0, 2'd1);
        tbl[11] = mk(1, 1'b1, 32'd12, 1'b1, 1'b0, 32'h0,    1'b0, 2'd1);
        tbl[12] = mk(1, 1'b0, 32'd0,  1'b0, 1'b0, 32'h0,    1'b0, 2'd2);
        tbl[13] = mk(1, 1'b0, 32'd0,  1'b0, 1'b1, prog[2],  1'b0, 2'd2);
        tbl[14] = mk(1, 1'b0, 32'd0,  1'b0, 1'b1, prog[3],  1'b0, 2'd1);
        tbl[15] = mk(1, 1'b0, 32'd0,  1'b0, 1'b0, 32'h0,    1'b0, 2'd0);
        // Misaligned and out-of-range addresses, then a legal fetch
        tbl[16] = mk(0, 1'b1, 32'h6,       1'b1, 1'b0, 32'h0,   1'b0, 2'd0);
        tbl[17] = mk(0, 1'b1, 32'(4*DEPTH), 1'b1, 1'b1, 32'h0,  1'b1, 2'd1);
        tbl[18] = mk(0, 1'b1, 32'd0,       1'b1, 1'b1, 32'h0,   1'b1, 2'd1);
        tbl[19] = mk(0, 1'b0, 32'd0,       1'b0, 1'b1, prog[0], 1'b0, 2'd1);
        tbl[20] = mk(0, 1'b0, 32'd0,       1'b0, 1'b0, 32'h0,   1'b0, 2'd0);

        repeat (3) step();
        rst_n = 1'b1;
        repeat (3) step();

        for (int w = 0; w < DEPTH; w++) begin
            for (int i = 0; i < 2; i++)
                set_load(i, 1'b1, IDX_W'(w), (w < 4) ? prog[w] : $urandom());
            step();
        end
        idle_all();
        step();

        for (int k = 0; k < 21; k++) run_row(k, tbl[k]);
        drain("tables");

        // Stall held for three cycles at address 8 on the latency-3 instance
        apply_stimulus(1, 1'b1, 32'd8, 1'b1);
        for (int k = 0; k < 3; k++) begin
            to_negedge();
            check_val("stall.gnt_low", gnt_w[1], 0);
            advance();
        end
        apply_stimulus(1, 1'b1, 32'd8, 1'b0);
        to_negedge();
        check_val("stall.gnt_release", gnt_w[1], 1);
        advance();
        idle_all();
        for (int k = 1; k <= LAT1; k++) begin
            to_negedge();
            check_val($sformatf("stall.rvalid_at_%0d", k), rv_w[1], (k == LAT1) ? 1 : 0);
            if (k == LAT1) check_val("stall.rdata", rd_w[1], prog[2]);
            advance();
        end
        drain("stall");

        // Same-cycle preload and fetch of word 1 returns the old word
        apply_stimulus(0, 1'b1, 32'd4, 1'b0);
        set_load(0, 1'b1, IDX_W'(1), 32'hDEAD_BEEF);
        to_negedge();
        check_val("rbw.gnt", gnt_w[0], 1);
        advance();
        set_load(0, 1'b0, '0, '0);
        to_negedge();
        check_val("rbw.old_data", rd_w[0], prog[1]);
        advance();
        idle_all();
        to_negedge();
        check_val("rbw.new_valid", rv_w[0], 1);
        check_val("rbw.new_data", rd_w[0], 32'hDEAD_BEEF);
        advance();
        drain("rbw");

        // Reset pulse with two fetches in flight on the latency-3 instance
        apply_stimulus(1, 1'b1, 32'd0, 1'b0);
        step();
        apply_stimulus(1, 1'b1, 32'd4, 1'b0);
        to_negedge();
        check_val("rst.second_gnt", gnt_w[1], 1);
        advance();
        idle_all();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            to_negedge();
            check_val($sformatf("rst.quiet%0d.rvalid", k), rv_w[1], 0);
            check_val($sformatf("rst.quiet%0d.outstanding", k), out_w[1], 0);
            advance();
        end
        apply_stimulus(1, 1'b1, 32'd12, 1'b0);
        to_negedge();
        check_val("rst.refetch_gnt", gnt_w[1], 1);
        advance();
        idle_all();
        t = 0;
        while (t < 8 && rv_w[1] !== 1'b1) begin
            step();
            t++;
        end
        check_val("rst.refetch_seen", (t < 8) ? 1 : 0, 1);
        check_val("rst.refetch_data", rd_w[1], prog[3]);
        drain("reset");

        // Random traffic on both instances against the model
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 2; i++) begin
                r = $urandom_range(0, 9);
                if (r <= 6)      a = 32'($urandom_range(0, DEPTH - 1)) << 2;
                else if (r == 7) a = (32'($urandom_range(0, DEPTH - 1)) << 2) + 32'($urandom_range(1, 3));
                else             a = 32'(DEPTH + $urandom_range(0, 100)) << 2;
                apply_stimulus(i, $urandom_range(0, 3) != 0, a, $urandom_range(0, 4) == 0);
                set_load(i, $urandom_range(0, 2) == 0, IDX_W'($urandom_range(0, DEPTH - 1)),
                         $urandom());
            end
            step();
        end
        drain("random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_mem_responder.md
Name: instr_mem_responder

Overview:
- Responder end of the core's instruction-fetch bus (req/gnt/rvalid/addr/rdata).
- Instantiated in the testbench/SoC top as the instruction memory that the fetch stage initiates requests to.
- Holds a word-addressed instruction array, loadable through a side preload port.
- Returns in-order read responses with fixed, parameterised latency, a bounded number of outstanding requests and optional grant back-pressure.

Parameters:
- WORD_WIDTH, 32, data/address width of the fetch bus.
- DEPTH_WORDS, 1024, number of instruction words in the array (power of two).
- LATENCY, 1, cycles from grant cycle to rvalid cycle (legal range 1..8).
- MAX_OUTSTANDING, 2, maximum granted-but-unanswered requests (1..LATENCY+1).
- BASE_ADDR, 32'h0000_0000, byte address mapped to word 0.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr_req_i  in  1  fetch request; held by the initiator until granted.
- instr_addr_i  in  WORD_WIDTH  byte address of the request.
- instr_gnt_o  out  1  request accepted this cycle; address may change next cycle.
- instr_rvalid_o  out  1  instr_rdata_o/instr_err_o valid this cycle.
- instr_rdata_o  out  WORD_WIDTH  instruction word.
- instr_err_o  out  1  response is an access error (qualified by rvalid).
- stall_i  in  1  forces gnt low while high (back-pressure injection).
- load_we_i  in  1  preload write enable.
- load_addr_i  in  $clog2(DEPTH_WORDS)  preload word index.
- load_wdata_i  in  WORD_WIDTH  preload data.
- outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  current outstanding count.

Behaviour:
- Reset (async assert, sync deassert internally): instr_rvalid_o=0, instr_err_o=0, instr_rdata_o=0, outstanding_o=0, response pipeline cleared. Array contents are NOT reset.
- Reset mid-operation: all in-flight responses are dropped; no rvalid appears after rst_n deasserts until a new grant occurs.
- Grant (combinational): instr_gnt_o = instr_req_i & ~stall_i & (outstanding_o < MAX_OUTSTANDING). No grant during reset.
- Free-slot rule: a slot freed by an rvalid in cycle T is usable for a grant from cycle T+1 only.
- On grant in cycle T, the request is sampled: word index = (instr_addr_i - BASE_ADDR) >> 2. The array is read at grant time, so later preload writes do not alter that response.
- Error: an error response is returned if instr_addr_i[1:0] != 0 or the index is >= DEPTH_WORDS. It has rdata=0, err=1, and the same latency as a normal response.
- Response: instr_rvalid_o is high for exactly one cycle, in cycle T+LATENCY. Responses are strictly in grant order.
  - Implementation: a LATENCY-deep shift pipeline of {valid, err, data}.
  - Back-to-back grants give back-to-back rvalids.
- Outputs when instr_rvalid_o=0: instr_rdata_o and instr_err_o are held at 0.
- Outstanding counter:
  - +1 on grant, -1 on rvalid; net 0 when both occur in one cycle.
  - Never exceeds MAX_OUTSTANDING; never underflows.
- Preload:
  - load_we_i writes the array on the rising edge.
  - When a preload write and a grant target the same word in the same cycle, the response carries the OLD data (read-before-write).
  - Preload writes are allowed while fetches are in flight.
- No write path exists on the fetch bus.
- instr_req_i deasserted without a grant is legal (request withdrawn); no state changes.

Test Plan:
- Preload words 0..3 = 32'h00000013, 32'h00100093, 32'h00208113, 32'h003181b3; LATENCY=1; req held, addrs 0,4,8,12 back-to-back -> gnt every cycle; rvalid cycles 1..4 with the four words in order; outstanding_o stays 1.
- LATENCY=3, MAX_OUTSTANDING=2, req held continuously -> grants in cycles 0,1; no gnt in cycles 2,3; rvalid in cycles 3,4; next grant in cycle 4; outstanding_o never exceeds 2.
- stall_i high for cycles 2..4 with req held at addr 8 -> gnt low for cycles 2..4, gnt in cycle 5, rvalid with word 2 in cycle 5+LATENCY.
- addr 32'h0000_0006 then addr 4*DEPTH_WORDS -> two rvalids with err=1, rdata=0; the following legal fetch at addr 0 returns word 0 with err=0.
- Same-cycle preload of word 1 = 32'hDEADBEEF and grant at addr 4 -> response 32'h00100093; a re-fetch of addr 4 returns 32'hDEADBEEF.
- LATENCY=3, two grants in flight, rst_n pulsed low for one cycle -> no rvalid for 5 cycles after release, outstanding_o=0; preload contents intact on the next fetch.
